mem_io_responder: RTL and testbench

Memory/IO responder on the far side of the CPU's byte-wide memory bus (mem_a / mem_wr / data out / data in / io_buffer_full).
- Implements the 128 KB byte RAM with one-cycle read latency.
- Implements the IO window at mem_a[17:16]==2'b11: UART data port with TX FIFO and RX pass-through, cycle counter, and program-stop latch.
- Sits at SoC top level, between the CPU and the UART/host interface. Serves as both the simulation memory model and the FPGA memory/IO block.

---
 rtl/mem_io_responder.sv | 146 ++++++++++++++
 tb/tb_mem_io_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus IO window (UART TX FIFO / RX pass-through, cycle counter, stop latch).
module mem_io_responder #(
  parameter int RAM_ADDR_BITS = 17,
  parameter int TX_DEPTH_LOG  = 4,
  parameter     INIT_FILE     = "test.data"
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int DEPTH = 1 << TX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG:0] DEPTH_C     = (TX_DEPTH_LOG + 1)'(DEPTH);
  localparam logic [TX_DEPTH_LOG:0] NEAR_FULL_C = (TX_DEPTH_LOG + 1)'(DEPTH - 1);

  logic [7:0] ram [0:(1 << RAM_ADDR_BITS) - 1];

  logic                    io_sel_s;
  logic [2:0]              io_off_s;
  logic                    ram_we_s;
  logic                    ram_re_s;
  logic                    push_req_s;
  logic                    push_ok_s;
  logic                    pop_s;
  logic [7:0]              push_byte_s;
  logic                    unused_s;

  logic [7:0]              fifo_q [DEPTH];
  logic [TX_DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [TX_DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [TX_DEPTH_LOG:0]   count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    stop_q, stop_d;
  logic [31:0]             cycle_q, cycle_d;
  logic [31:0]             snap_q, snap_d;
  logic [7:0]              io_rdata_q, io_rdata_d;
  logic                    src_ram_q, src_ram_d;
  logic [7:0]              ram_rdata_q;

  assign io_sel_s = (mem_a[17:16] == 2'b11);
  assign io_off_s = mem_a[2:0];
  assign unused_s = ^mem_a[31:18];
  assign ram_we_s = !rst_in && mem_wr && !io_sel_s;
  assign ram_re_s = !rst_in && !mem_wr && !io_sel_s;

  // Offset-4 writes push the end-of-stream marker even though it is zero.
  assign push_req_s  = !rst_in && mem_wr && io_sel_s &&
                       (((io_off_s == 3'd0) && (mem_wdata != 8'h00)) || (io_off_s == 3'd4));
  assign push_byte_s = (io_off_s == 3'd4) ? 8'h00 : mem_wdata;
  assign pop_s       = (count_q != '0) && tx_ready;
  assign push_ok_s   = push_req_s && ((count_q != DEPTH_C) || pop_s);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    stop_d     = stop_q;
    cycle_d    = cycle_q;
    snap_d     = snap_q;
    io_rdata_d = io_rdata_q;
    src_ram_d  = src_ram_q;

    if (pop_s) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok_s) wr_ptr_d = wr_ptr_q + 1'b1;
    count_d = count_q + (TX_DEPTH_LOG + 1)'(push_ok_s) - (TX_DEPTH_LOG + 1)'(pop_s);
    if (push_req_s && !push_ok_s) overflow_d = 1'b1;

    if (mem_wr && io_sel_s && (io_off_s == 3'd4)) stop_d = 1'b1;
    if (!stop_q) cycle_d = cycle_q + 32'd1;

    // Writes leave both read sources untouched so mem_rdata holds.
    if (!mem_wr) begin
      if (io_sel_s) begin
        src_ram_d = 1'b0;
        case (io_off_s)
          3'd0:    io_rdata_d = rx_valid ? rx_data : 8'h00;
          3'd4: begin
            snap_d     = cycle_q;
            io_rdata_d = cycle_q[7:0];
          end
          3'd5:    io_rdata_d = snap_q[15:8];
          3'd6:    io_rdata_d = snap_q[23:16];
          3'd7:    io_rdata_d = snap_q[31:24];
          default: io_rdata_d = 8'h00;
        endcase
      end else begin
        src_ram_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      stop_q     <= 1'b0;
      cycle_q    <= 32'd0;
      snap_q     <= 32'd0;
      io_rdata_q <= 8'h00;
      src_ram_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      stop_q     <= stop_d;
      cycle_q    <= cycle_d;
      snap_q     <= snap_d;
      io_rdata_q <= io_rdata_d;
      src_ram_q  <= src_ram_d;
    end
  end

  // RAM and FIFO storage carry no reset so they map onto block memory.
  always_ff @(posedge clk_in) begin
    if (ram_we_s) ram[mem_a[RAM_ADDR_BITS-1:0]] <= mem_wdata;
    if (ram_re_s) ram_rdata_q <= ram[mem_a[RAM_ADDR_BITS-1:0]];
  end

  always_ff @(posedge clk_in) begin
    if (push_ok_s) fifo_q[wr_ptr_q] <= push_byte_s;
  end

  assign mem_rdata      = src_ram_q ? ram_rdata_q : io_rdata_q;
  assign tx_valid       = (count_q != '0);
  assign tx_data        = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;
  assign io_buffer_full = (count_q >= NEAR_FULL_C);
  assign program_stop   = stop_q;
  assign tx_overflow    = overflow_q;
  assign rx_ready       = !rst_in && !mem_wr && io_sel_s && (io_off_s == 3'd0) && rx_valid;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: driver updates a behavioural model, monitor compares.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;
  logic        tx_overflow;

  always #5 clk_in = ~clk_in;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       rxr;
    logic       txv;
    logic [7:0] txd;
    logic       full;
    logic       stop;
    logic       ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Reference model state
  logic [7:0]  ram_m [int];
  logic [7:0]  txq[$];
  logic [31:0] cnt_m  = 32'd0;
  logic [31:0] snap_m = 32'd0;
  logic        stop_m = 1'b0;
  logic        ovf_m  = 1'b0;
  logic [7:0]  rd_m   = 8'h00;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] a, input logic wr, input logic [7:0] wd,
                      input logic txr, input logic rxv, input logic [7:0] rxd);
    exp_t       e;
    logic       io;
    logic [2:0] off;
    logic       pop;
    logic       push;
    logic [7:0] pb;
    logic       rxr;
    @(negedge clk_in);
    #1;
    rst_in = rst; mem_a = a; mem_wr = wr; mem_wdata = wd;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    @(posedge clk_in);
    rxr = 1'b0;
    if (rst) begin
      rd_m = 8'h00; txq.delete(); cnt_m = 32'd0; snap_m = 32'd0; stop_m = 1'b0; ovf_m = 1'b0;
    end else begin
      io   = (a[17:16] == 2'b11);
      off  = a[2:0];
      pop  = (txq.size() != 0) && txr;
      push = 1'b0;
      pb   = 8'h00;
      if (!wr) begin
        if (!io) rd_m = ram_m[int'(a[16:0])];
        else begin
          case (off)
            3'd0: begin rd_m = rxv ? rxd : 8'h00; rxr = rxv; end
            3'd4: begin snap_m = cnt_m; rd_m = snap_m[7:0]; end
            3'd5: rd_m = snap_m[15:8];
            3'd6: rd_m = snap_m[23:16];
            3'd7: rd_m = snap_m[31:24];
            default: rd_m = 8'h00;
          endcase
        end
      end else if (!io) begin
        ram_m[int'(a[16:0])] = wd;
      end else if (off == 3'd0 && wd != 8'h00) begin
        push = 1'b1; pb = wd;
      end else if (off == 3'd4) begin
        push = 1'b1; pb = 8'h00;
      end
      if (pop) void'(txq.pop_front());
      if (push) begin
        if (txq.size() < 16) txq.push_back(pb);
        else ovf_m = 1'b1;
      end
      if (!stop_m) cnt_m = cnt_m + 32'd1;
      if (wr && io && off == 3'd4) stop_m = 1'b1;
    end
    e.rdata = rd_m;
    e.rxr   = rxr;
    e.txv   = (txq.size() != 0);
    e.txd   = e.txv ? txq[0] : 8'h00;
    e.full  = (txq.size() >= 15);
    e.stop  = stop_m;
    e.ovf   = ovf_m;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every observable output against the expectation queued at the last edge
  always @(negedge clk_in) begin : mon
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("mem_rdata", mem_rdata, e.rdata);
      chk("rx_ready", {7'd0, rx_ready}, {7'd0, e.rxr});
      chk("tx_valid", {7'd0, tx_valid}, {7'd0, e.txv});
      chk("tx_data", tx_data, e.txd);
      chk("io_buffer_full", {7'd0, io_buffer_full}, {7'd0, e.full});
      chk("program_stop", {7'd0, program_stop}, {7'd0, e.stop});
      chk("tx_overflow", {7'd0, tx_overflow}, {7'd0, e.ovf});
    end
  end

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0003_0001, 1'b1, 8'h00, txr, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] a;
    logic        wr;
    logic [7:0]  msg [4];
    rst_in = 1'b1; mem_a = 32'd0; mem_wr = 1'b0; mem_wdata = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h00; msg[3] = 8'h21;

    for (int i = 0; i < 3; i++) step(1'b1, 32'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // RAM write then read-back, including the top address
    step(1'b0, 32'h0000_0010, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h0001_FFFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h0000_0010, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 32; i++)
      step(1'b0, 32'(i), 1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);

    // UART TX with zero skip, then drain
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0003_0000, 1'b1, msg[i], 1'b0, 1'b0, 8'h00);
    idle(5, 1'b1);

    // FIFO fill, near-full, overflow, push-at-full with pop
    for (int i = 1; i <= 17; i++) step(1'b0, 32'h0003_0000, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h0003_0000, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00);
    idle(20, 1'b1);

    // RX pass-through with and without valid data
    step(1'b0, 32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41);
    step(1'b0, 32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h55);
    step(1'b0, 32'h0003_0003, 1'b0, 8'h00, 1'b0, 1'b1, 8'h66);

    // Counter snapshot stays coherent while the live counter keeps running
    step(1'b0, 32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(300, 1'b0);
    for (int i = 5; i < 8; i++) step(1'b0, 32'h0003_0000 + 32'(i), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Randomized traffic over the prewritten RAM range and the whole IO window
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 4) a = 32'($urandom_range(0, 31));
      else a = 32'h0003_0000 + 32'($urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1));
      if (wr && a[17:16] == 2'b11 && a[2:0] == 3'd4 && $urandom_range(0, 19) != 0) wr = 1'b0;
      step(1'b0, a, wr, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Stop latch, frozen counter, then reset mid-read with RAM retained
    step(1'b0, 32'h0003_0004, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(10, 1'b0);
    step(1'b0, 32'h0003_0004, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step(1'b0, 32'h0001_FFFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b1, 32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b1, 32'h0000_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h0001_FFFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(5, 1'b0);
    step(1'b0, 32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    repeat (3) @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
